// File: rtl/sd_pic_seq_loader.sv
// sd_pic_seq_loader: boot preload of NUM_PIC BMP pictures from SD to SDRAM; start/rd_busy/sd_rd_val_* in, rd_start_en/rd_sec_addr and tbl_idx/tbl_* lookup, RGB565 sdram_wr_* out, pic_switch/pic_load_done status
module sd_pic_seq_loader #(
  parameter int NUM_PIC = 6,
  parameter int IDX_W = 3,
  parameter int HDR_WORDS = 27,
  parameter int SWITCH_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rd_busy,
  input  logic             sd_rd_val_en,
  input  logic [15:0]      sd_rd_val_data,
  output logic             rd_start_en,
  output logic [31:0]      rd_sec_addr,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [31:0]      tbl_sec_addr,
  input  logic [15:0]      tbl_sec_num,
  input  logic [23:0]      tbl_pix_num,
  input  logic [23:0]      tbl_base_addr,
  output logic             sdram_wr_en,
  output logic [15:0]      sdram_wr_data,
  output logic [23:0]      sdram_base_addr,
  output logic             pic_switch,
  output logic             pic_load_done
);
  localparam int SW_W = $clog2(SWITCH_CYC + 1);
  localparam int SK_W = $clog2(HDR_WORDS + 1);
  typedef enum logic [2:0] {IDLE, SWITCH, RD_REQ, WAIT_BUSY, WAIT_DONE, NEXT, DONE} state_t;
  state_t state, next;
  logic [SW_W-1:0] sw_cnt;
  logic [SK_W-1:0] skip;
  logic [15:0] sec_cnt;
  logic [23:0] pix_cnt;
  logic [1:0] phase;
  logic [5:0] g0;
  logic [4:0] b0, b1;
  logic more_sec, take, unused_bits;
  assign more_sec = {1'b0, sec_cnt} + 17'd1 < {1'b0, tbl_sec_num};
  assign take = sd_rd_val_en && (state == WAIT_BUSY || state == WAIT_DONE);
  assign pic_switch = state == SWITCH;
  assign pic_load_done = state == DONE;
  assign unused_bits = ^{sd_rd_val_data[9:8], sd_rd_val_data[1:0]};
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start ? SWITCH : state;
      SWITCH:     next = sw_cnt == SW_W'(SWITCH_CYC - 1) ? RD_REQ : SWITCH;
      RD_REQ:     next = WAIT_BUSY;
      WAIT_BUSY:  next = rd_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE:  next = rd_busy ? WAIT_DONE : NEXT;
      NEXT:       next = more_sec ? RD_REQ : tbl_idx < IDX_W'(NUM_PIC - 1) ? SWITCH : DONE;
      default:    next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_start_en <= 1'b0;
      rd_sec_addr <= '0;
      tbl_idx <= '0;
      sdram_wr_en <= 1'b0;
      sdram_wr_data <= '0;
      sdram_base_addr <= '0;
      sw_cnt <= '0;
      skip <= '0;
      sec_cnt <= '0;
      pix_cnt <= '0;
      phase <= '0;
      g0 <= '0;
      b0 <= '0;
      b1 <= '0;
    end else begin
      rd_start_en <= state == RD_REQ;
      sdram_wr_en <= 1'b0;
      sw_cnt <= state == SWITCH ? sw_cnt + 1'b1 : '0;
      if (state == RD_REQ) rd_sec_addr <= tbl_sec_addr + {16'd0, sec_cnt};
      if ((state == IDLE || state == DONE) && start) tbl_idx <= '0;
      if (state == NEXT && next == SWITCH) tbl_idx <= tbl_idx + 1'b1;
      if (state == NEXT && more_sec) sec_cnt <= sec_cnt + 1'b1;
      if (state == SWITCH) begin
        sdram_base_addr <= tbl_base_addr;
        sec_cnt <= '0;
        pix_cnt <= '0;
        phase <= '0;
        skip <= SK_W'(HDR_WORDS);
      end else if (take) begin
        if (skip != '0) skip <= skip - 1'b1;
        else if (pix_cnt != tbl_pix_num) begin
          phase <= phase == 2'd2 ? 2'd0 : phase + 2'd1;
          if (phase == 2'd0) begin
            g0 <= sd_rd_val_data[15:10];
            b0 <= sd_rd_val_data[7:3];
          end
          if (phase == 2'd1) b1 <= sd_rd_val_data[15:11];
          if (phase != 2'd0) begin
            sdram_wr_en <= 1'b1;
            sdram_wr_data <= phase == 2'd1 ? {sd_rd_val_data[7:3], g0, b0} : {sd_rd_val_data[15:11], sd_rd_val_data[7:2], b1};
            pix_cnt <= pix_cnt + 24'd1;
          end
        end
      end
    end
  end
endmodule
